// File: rtl/alu_issue_stage_pkg.sv
// Shared constants and payload type for the ALU issue stage and the ALU behind it.
package alu_issue_stage_pkg;

    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_SLL  = 6'd1;
    localparam logic [5:0] ALU_SLT  = 6'd2;
    localparam logic [5:0] ALU_SLTU = 6'd3;
    localparam logic [5:0] ALU_XOR  = 6'd4;
    localparam logic [5:0] ALU_SRL  = 6'd5;
    localparam logic [5:0] ALU_OR   = 6'd6;
    localparam logic [5:0] ALU_AND  = 6'd7;
    localparam logic [5:0] ALU_SRA  = 6'd8;
    localparam logic [5:0] ALU_SUB  = 6'd9;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [5:0]  alu_op;
        logic [31:0] rv1;
        logic [31:0] rv2;
        logic [4:0]  rd;
        logic        wr_en;
        logic        illegal;
    } issue_payload_t;

    function automatic logic [5:0] f3_to_op(input logic [2:0] funct3);
        logic [5:0] op;
        case (funct3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic is_shift(input logic [5:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_issue_stage_skid_buffer.sv
// Two-entry valid/ready register pair: a main output register plus one skid entry,
// giving full throughput with a registered in_ready.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] data_p1;
    logic [W-1:0] skid_data;
    logic         vld_p1;
    logic         skid_vld;
    logic         in_rdy_q;
    logic         in_fire;
    logic         main_free;

    assign in_fire   = in_valid & in_rdy_q;
    assign main_free = !vld_p1 | out_ready;

    // in_rdy_q always mirrors !skid_vld, so a skid refill can never coincide with a drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_p1   <= '0;
            skid_data <= '0;
            vld_p1    <= 1'b0;
            skid_vld  <= 1'b0;
            in_rdy_q  <= 1'b1;
        end else if (main_free) begin
            if (skid_vld) begin
                data_p1  <= skid_data;
                vld_p1   <= 1'b1;
                skid_vld <= 1'b0;
                in_rdy_q <= 1'b1;
            end else begin
                vld_p1 <= in_fire;
                if (in_fire) data_p1 <= in_data;
            end
        end else if (in_fire) begin
            skid_data <= in_data;
            skid_vld  <= 1'b1;
            in_rdy_q  <= 1'b0;
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = vld_p1;
    assign out_data  = data_p1;

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM decode and issue stage feeding the combinational ALU.
// Decode is combinational on the input side; the result is registered through a skid buffer.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       alu_op,
    output logic [XLEN-1:0]  alu_rv1,
    output logic [XLEN-1:0]  alu_rv2,
    output logic [4:0]       rd,
    output logic             wr_en,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic signed [XLEN-1:0] imm_sext;
    logic [5:0]             rr_op;
    logic                   rr_ill;
    logic [5:0]             dec_op;
    logic [XLEN-1:0]        dec_rv2;
    logic                   dec_ill;
    logic                   unused_rs1_idx;
    issue_payload_t         payload_p0;
    issue_payload_t         payload_p1;

    assign opcode         = instr[6:0];
    assign funct3         = instr[14:12];
    assign funct7         = instr[31:25];
    assign imm_sext       = XLEN'($signed(instr[31:20]));
    assign unused_rs1_idx = ^instr[19:15];

    // funct7 legality shared by register ops and immediate shifts
    always_comb begin
        rr_op  = ALU_ADD;
        rr_ill = 1'b0;
        if (funct7 == F7_BASE)
            rr_op = f3_to_op(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000)
            rr_op = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)
            rr_op = ALU_SRA;
        else
            rr_ill = 1'b1;
    end

    always_comb begin
        dec_op  = ALU_ADD;
        dec_ill = 1'b0;
        dec_rv2 = rs2_data;
        case (opcode)
            OPC_OP: begin
                dec_op  = rr_op;
                dec_ill = rr_ill;
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_rv2 = {{(XLEN-5){1'b0}}, instr[24:20]};
                    dec_op  = rr_op;
                    dec_ill = rr_ill;
                end else begin
                    dec_rv2 = imm_sext;
                    dec_op  = f3_to_op(funct3);
                end
            end
            default: dec_ill = 1'b1;
        endcase
        if (is_shift(dec_op)) dec_rv2[XLEN-1:5] = '0;
        if (dec_ill) dec_op = ALU_ADD;
    end

    assign payload_p0.alu_op  = dec_op;
    assign payload_p0.rv1     = rs1_data;
    assign payload_p0.rv2     = dec_rv2;
    assign payload_p0.rd      = instr[11:7];
    assign payload_p0.wr_en   = !dec_ill && (instr[11:7] != 5'd0);
    assign payload_p0.illegal = dec_ill;

    // ---- stage boundary: decoded payload registered in the skid pair ----
    skid_buffer #(
        .W($bits(issue_payload_t))
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (payload_p0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (payload_p1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            issue_cnt <= '0;
        else if (out_valid && out_ready)
            issue_cnt <= sat_inc(issue_cnt);
    end

    assign alu_op  = payload_p1.alu_op;
    assign alu_rv1 = payload_p1.rv1;
    assign alu_rv2 = payload_p1.rv2;
    assign rd      = payload_p1.rd;
    assign wr_en   = payload_p1.wr_en;
    assign illegal = payload_p1.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed RV32I cases, back-pressure, reset, then random traffic
// compared against a queue-based reference of the issue stage.
module tb_alu_issue_stage;

    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      instr = '0;
    logic [31:0]      rs1_data = '0;
    logic [31:0]      rs2_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [5:0]       alu_op;
    logic [31:0]      alu_rv1;
    logic [31:0]      alu_rv2;
    logic [4:0]       rd;
    logic             wr_en;
    logic             illegal;
    logic [CNT_W-1:0] issue_cnt;

    alu_issue_stage #(
        .XLEN  (32),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .alu_rv1   (alu_rv1),
        .alu_rv2   (alu_rv2),
        .rd        (rd),
        .wr_en     (wr_en),
        .illegal   (illegal),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;
        logic [31:0] rv1;
        logic [31:0] rv2;
        logic [4:0]  rd;
        bit          wr;
        bit          ill;
    } exp_t;

    exp_t q[$];
    int   cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] a,
                                        input logic [31:0] b);
        exp_t e;
        int   f3;
        logic [6:0] opc;
        logic [6:0] f7;
        opc   = w[6:0];
        f7    = w[31:25];
        f3    = int'(w[14:12]);
        e.rv1 = a;
        e.rv2 = b;
        e.rd  = w[11:7];
        e.ill = 1'b0;
        e.op  = 0;
        if (opc == 7'h33 || (opc == 7'h13 && (f3 == 1 || f3 == 5))) begin
            if (opc == 7'h13) e.rv2 = {27'd0, w[24:20]};
            if (f7 == 7'h00) e.op = f3;
            else if (f7 == 7'h20 && f3 == 0 && opc == 7'h33) e.op = 9;
            else if (f7 == 7'h20 && f3 == 5) e.op = 8;
            else e.ill = 1'b1;
        end else if (opc == 7'h13) begin
            e.rv2 = {{20{w[31]}}, w[31:20]};
            e.op  = f3;
        end else begin
            e.ill = 1'b1;
        end
        if (e.op == 1 || e.op == 5 || e.op == 8) e.rv2 = e.rv2 % 32;
        if (e.ill) e.op = 0;
        e.wr = !e.ill && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rdd, input logic [6:0] opc);
        return {f7, r2, r1, f3, rdd, opc};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int s;
        w = $urandom;
        s = $urandom_range(0, 9);
        if (s < 4) w[6:0] = 7'h33;
        else if (s < 8) w[6:0] = 7'h13;
        s = $urandom_range(0, 3);
        if (s == 0) w[31:25] = 7'h00;
        else if (s == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    task automatic check_all();
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("issue_cnt", {28'd0, issue_cnt}, cnt);
        if (q.size() != 0) begin
            chk("alu_op", {26'd0, alu_op}, q[0].op);
            chk("alu_rv1", alu_rv1, q[0].rv1);
            if (!q[0].ill) chk("alu_rv2", alu_rv2, q[0].rv2);
            chk("rd", {27'd0, rd}, {27'd0, q[0].rd});
            chk("wr_en", {31'd0, wr_en}, {31'd0, q[0].wr});
            chk("illegal", {31'd0, illegal}, {31'd0, q[0].ill});
        end
    endtask

    // one clock: check outputs against the reference, advance both
    task automatic cycle(output bit acc);
        bit emit;
        check_all();
        acc  = in_valid && (q.size() < 2);
        emit = (q.size() != 0) && out_ready;
        @(posedge clk);
        #1;
        if (emit) begin
            q.delete(0);
            if (cnt < CMAX) cnt++;
        end
        if (acc) q.push_back(ref_decode(instr, rs1_data, rs2_data));
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        q.delete();
        cnt = 0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_issue_cnt", {28'd0, issue_cnt}, 32'd0);
        chk("rst_alu_op", {26'd0, alu_op}, 32'd0);
        chk("rst_rv2", alu_rv2, 32'd0);
        chk("rst_rd_wr_ill", {27'd0, rd, wr_en, illegal}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input string tag, input logic [31:0] w, input logic [31:0] a,
                         input logic [31:0] b, input int op, input logic [31:0] rv2,
                         input bit chk_rv2, input logic [4:0] rdd, input bit wr, input bit ill);
        bit acc;
        instr     = w;
        rs1_data  = a;
        rs2_data  = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        chk({tag, "_accepted"}, {31'd0, acc}, 32'd1);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_op"}, {26'd0, alu_op}, op);
        chk({tag, "_rv1"}, alu_rv1, a);
        if (chk_rv2) chk({tag, "_rv2"}, alu_rv2, rv2);
        chk({tag, "_rd"}, {27'd0, rd}, {27'd0, rdd});
        chk({tag, "_wr"}, {31'd0, wr_en}, {31'd0, wr});
        chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, ill});
        cycle(acc);
    endtask

    initial begin
        bit acc;
        int idx;
        logic [31:0] st[4];

        @(posedge clk);
        #1;
        apply_reset();

        send1("add", enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33), 32'd5, 32'd7,
              0, 32'd7, 1'b1, 5'd3, 1'b1, 1'b0);
        send1("sub", enc(7'h20, 5'd7, 5'd6, 3'b000, 5'd5, 7'h33), 32'd10, 32'd3,
              9, 32'd3, 1'b1, 5'd5, 1'b1, 1'b0);
        send1("sra", enc(7'h20, 5'd7, 5'd6, 3'b101, 5'd5, 7'h33), 32'h80000000, 32'hFFFFFF21,
              8, 32'd1, 1'b1, 5'd5, 1'b1, 1'b0);
        send1("srai", 32'h4030D213, 32'hF0000000, 32'hDEADBEEF,
              8, 32'd3, 1'b1, 5'd4, 1'b1, 1'b0);
        send1("addi_m1", enc(7'h7F, 5'h1F, 5'd2, 3'b000, 5'd1, 7'h13), 32'd9, 32'd0,
              0, 32'hFFFFFFFF, 1'b1, 5'd1, 1'b1, 1'b0);
        send1("sll", enc(7'h00, 5'd3, 5'd2, 3'b001, 5'd1, 7'h33), 32'd1, 32'h00000123,
              1, 32'd3, 1'b1, 5'd1, 1'b1, 1'b0);
        send1("addi_x0", enc(7'h00, 5'd1, 5'd0, 3'b000, 5'd0, 7'h13), 32'd0, 32'd0,
              0, 32'd1, 1'b1, 5'd0, 1'b0, 1'b0);
        send1("load", enc(7'h00, 5'd0, 5'd1, 3'b010, 5'd5, 7'b0000011), 32'd4, 32'd8,
              0, 32'd0, 1'b0, 5'd5, 1'b0, 1'b1);
        send1("mul", enc(7'h01, 5'd2, 5'd1, 3'b000, 5'd6, 7'h33), 32'd4, 32'd8,
              0, 32'd0, 1'b0, 5'd6, 1'b0, 1'b1);
        send1("slli_badf7", enc(7'h20, 5'd2, 5'd1, 3'b001, 5'd6, 7'h13), 32'd4, 32'd8,
              0, 32'd0, 1'b0, 5'd6, 1'b0, 1'b1);

        // back-pressure: four words, out_ready low for the first three cycles
        apply_reset();
        st[0] = enc(7'h00, 5'd2, 5'd1, 3'b100, 5'd7, 7'h33);
        st[1] = enc(7'h00, 5'd2, 5'd1, 3'b110, 5'd8, 7'h33);
        st[2] = enc(7'h00, 5'd2, 5'd1, 3'b111, 5'd9, 7'h33);
        st[3] = enc(7'h20, 5'd2, 5'd1, 3'b000, 5'd10, 7'h33);
        idx = 0;
        for (int c = 0; c < 20 && !(idx == 4 && q.size() == 0); c++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin
                instr    = st[idx];
                rs1_data = 32'h100 + idx;
                rs2_data = 32'h200 + idx;
            end
            out_ready = (c >= 3);
            if (c == 2) chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            cycle(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_all_drained", {31'd0, (idx == 4) && (q.size() == 0)}, 32'd1);
        chk("bp_issue_cnt", {28'd0, issue_cnt}, 32'd4);

        // reset with both entries occupied
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = enc(7'h00, 5'd2, 5'd1, 3'b011, 5'd11, 7'h33);
        cycle(acc);
        instr     = enc(7'h00, 5'd2, 5'd1, 3'b010, 5'd12, 7'h33);
        cycle(acc);
        in_valid = 1'b0;
        chk("full_before_reset", {31'd0, in_ready}, 32'd0);
        apply_reset();
        send1("post_reset", enc(7'h00, 5'd2, 5'd1, 3'b011, 5'd13, 7'h33), 32'd1, 32'd2,
              3, 32'd2, 1'b1, 5'd13, 1'b1, 1'b0);

        // random traffic; an unaccepted word is held until taken
        acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                instr    = gen_instr();
                rs1_data = $urandom;
                rs2_data = $urandom;
            end
            out_ready = ($urandom_range(0, 9) < 6);
            cycle(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle(acc);
        chk("drained", {31'd0, out_valid}, 32'd0);
        chk("cnt_saturated", {28'd0, issue_cnt}, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
